// File: rtl/bcrypt_core_arbiter_pkg.sv
// Shared definitions for the bcrypt core arbiter: FSM encodings, byte-lane
// geometry and the lane strobe helper.
package bcrypt_core_arbiter_pkg;

  localparam int LANE_W  = 2;
  localparam int N_LANES = 4;

  localparam logic IN_TYPE_INIT  = 1'b0;
  localparam logic IN_TYPE_CRYPT = 1'b1;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_WAIT_INIT,
    IN_WAIT_CRYPT,
    IN_XFER
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_RD,
    OUT_SYNC,
    OUT_SHIFT
  } out_state_e;

  function automatic logic [N_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    return N_LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first requester at or after ptr_i, wrapping N-1 -> 0.
module rr_select #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] gnt_o,
  output logic          vld_o
);

  logic [PW:0] idx;

  // Walk from the farthest candidate back to ptr so the closest hit wins.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_i} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (req_i[idx[PW-1:0]]) begin
        gnt_o = idx[PW-1:0];
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcrypt_core_arbiter.sv
// Distributes init/crypt packets to a bank of bcrypt cores and serialises
// their result bitstreams back into bytes; input and output sides run independently.
module bcrypt_core_arbiter
  import bcrypt_core_arbiter_pkg::*;
#(
  parameter int N_CORES   = 4,
  parameter int OUT_NBITS = 288
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       in_type,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [7:0]                 core_din,
  output logic [N_LANES*N_CORES-1:0] core_byte_wr_en,
  output logic                       core_start,
  input  logic [N_CORES-1:0]         core_init_ready,
  input  logic [N_CORES-1:0]         core_crypt_ready,
  input  logic [N_CORES-1:0]         core_empty,
  output logic [N_CORES-1:0]         core_rd_en,
  input  logic [N_CORES-1:0]         core_dout,
  output logic [7:0]                 out_data,
  output logic                       out_valid
);

  localparam int PW = $clog2(N_CORES);
  localparam int CW = $clog2(OUT_NBITS + 1);

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
    return (g == PW'(N_CORES - 1)) ? '0 : g + 1'b1;
  endfunction

  // ---------------- input side ----------------
  in_state_e                    in_st_q;
  logic [N_CORES-1:0]           tgt_q;
  logic [PW-1:0]                in_ptr_q;
  logic [LANE_W-1:0]            lane_q;
  logic                         first_q;
  logic                         in_ready_q;
  logic [7:0]                   din_q;
  logic [N_LANES*N_CORES-1:0]   wr_en_q, wr_en_d;
  logic                         start_q;
  logic [PW-1:0]                in_gnt;
  logic                         in_gnt_vld;

  rr_select #(.N(N_CORES), .PW(PW)) u_in_rr (
    .req_i (core_crypt_ready),
    .ptr_i (in_ptr_q),
    .gnt_o (in_gnt),
    .vld_o (in_gnt_vld)
  );

  always_comb begin
    wr_en_d = '0;
    for (int i = 0; i < N_CORES; i++)
      wr_en_d[i*N_LANES +: N_LANES] = tgt_q[i] ? lane_onehot(lane_q) : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_st_q    <= IN_IDLE;
      tgt_q      <= '0;
      in_ptr_q   <= '0;
      lane_q     <= '0;
      first_q    <= 1'b0;
      in_ready_q <= 1'b0;
      din_q      <= '0;
      wr_en_q    <= '0;
      start_q    <= 1'b0;
    end else begin
      wr_en_q <= '0;
      start_q <= 1'b0;
      case (in_st_q)
        IN_IDLE: begin
          // The first byte stays on the bus until a target is chosen.
          if (in_valid)
            in_st_q <= (in_type == IN_TYPE_CRYPT) ? IN_WAIT_CRYPT : IN_WAIT_INIT;
        end
        IN_WAIT_INIT: begin
          if (&core_init_ready) begin
            tgt_q      <= '1;
            lane_q     <= '0;
            first_q    <= 1'b1;
            in_ready_q <= 1'b1;
            in_st_q    <= IN_XFER;
          end
        end
        IN_WAIT_CRYPT: begin
          if (in_gnt_vld) begin
            tgt_q      <= N_CORES'(1) << in_gnt;
            in_ptr_q   <= ptr_next(in_gnt);
            lane_q     <= '0;
            first_q    <= 1'b1;
            in_ready_q <= 1'b1;
            in_st_q    <= IN_XFER;
          end
        end
        IN_XFER: begin
          if (in_valid) begin
            din_q   <= in_data;
            wr_en_q <= wr_en_d;
            start_q <= first_q;
            first_q <= 1'b0;
            lane_q  <= lane_q + 1'b1;
            if (in_last) begin
              lane_q     <= '0;
              in_ready_q <= 1'b0;
              in_st_q    <= IN_IDLE;
            end
          end
        end
        default: in_st_q <= IN_IDLE;
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign core_din        = din_q;
  assign core_byte_wr_en = wr_en_q;
  assign core_start      = start_q;

  // ---------------- output side ----------------
  out_state_e         out_st_q;
  logic [PW-1:0]      out_ptr_q;
  logic [PW-1:0]      sel_q;
  logic [N_CORES-1:0] rd_en_q;
  logic [CW-1:0]      bit_cnt_q;
  logic [7:0]         sh_q;
  logic [7:0]         out_data_q;
  logic               out_valid_q;
  logic [PW-1:0]      out_gnt;
  logic               out_gnt_vld;
  logic               sbit;

  rr_select #(.N(N_CORES), .PW(PW)) u_out_rr (
    .req_i (~core_empty),
    .ptr_i (out_ptr_q),
    .gnt_o (out_gnt),
    .vld_o (out_gnt_vld)
  );

  assign sbit = core_dout[sel_q];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_st_q    <= OUT_IDLE;
      out_ptr_q   <= '0;
      sel_q       <= '0;
      rd_en_q     <= '0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_en_q     <= '0;
      out_valid_q <= 1'b0;
      case (out_st_q)
        OUT_IDLE: begin
          if (out_gnt_vld) begin
            sel_q     <= out_gnt;
            rd_en_q   <= N_CORES'(1) << out_gnt;
            out_ptr_q <= ptr_next(out_gnt);
            out_st_q  <= OUT_RD;
          end
        end
        OUT_RD: out_st_q <= OUT_SYNC;
        OUT_SYNC: begin
          if (sbit) begin
            bit_cnt_q <= '0;
            out_st_q  <= OUT_SHIFT;
          end
        end
        OUT_SHIFT: begin
          // Bits arrive LSB first; the shifter fills from the top.
          sh_q      <= {sbit, sh_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            out_data_q  <= {sbit, sh_q[7:1]};
            out_valid_q <= 1'b1;
          end
          if (bit_cnt_q == CW'(OUT_NBITS - 1)) out_st_q <= OUT_IDLE;
        end
        default: out_st_q <= OUT_IDLE;
      endcase
    end
  end

  assign core_rd_en = rd_en_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

endmodule
